// File: rtl/int_ctrl.sv
// int_ctrl: device interrupt controller feeding CP0 HWINT[7:2].
// Synchronizes sources, latches edge/level pending bits, tracks one in-service source.
module int_ctrl #(
    parameter int unsigned NSRC    = 6,
    parameter logic [2:0]  NONE_ID = 3'd7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [1:0]      exl_op,
    output logic [NSRC-1:0] hwint,
    output logic [2:0]      cur_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        EXCEPT  = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_PEND   = 2'd0;
    localparam logic [1:0] ADDR_ENABLE = 2'd1;
    localparam logic [1:0] ADDR_MODE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] EXL_ENTRY = 2'd1;
    localparam logic [1:0] EXL_ERET  = 2'd2;

    localparam logic [NSRC-1:0] ENABLE_RST = '1;

    logic [NSRC-1:0] s1_q, s1_d;
    logic [NSRC-1:0] s2_q, s2_d;
    logic [NSRC-1:0] s3_q, s3_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    state_e          state_q, state_d;
    logic [2:0]      cur_id_q, cur_id_d;

    logic            wr_pend;
    logic            wr_enable;
    logic            wr_mode;
    logic [NSRC-1:0] wr_bits;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr_mask;
    logic [NSRC-1:0] mode_chg;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] lower_mask;
    logic [2:0]      req_id;
    logic            unused_wdata;

    assign wr_bits      = wdata[NSRC-1:0];
    assign unused_wdata = ^wdata[31:NSRC];
    assign cur_id       = cur_id_q;
    assign req          = pend_q & enable_q;

    // Decode bus writes; STATUS is read-only so it has no strobe.
    always_comb begin
        wr_pend   = 1'b0;
        wr_enable = 1'b0;
        wr_mode   = 1'b0;
        if (sel && we) begin
            unique case (addr)
                ADDR_PEND:   wr_pend   = 1'b1;
                ADDR_ENABLE: wr_enable = 1'b1;
                ADDR_MODE:   wr_mode   = 1'b1;
                default:     ;
            endcase
        end
    end

    // Synchronizer chain; s3 keeps the previous s2 for edge detection.
    always_comb begin
        s1_d = irq_src;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Pending bits: edge bits latch until cleared, level bits track s2.
    // A fresh edge beats a same-cycle software clear; a mode change clears.
    always_comb begin
        rise     = s2_q & ~s3_q;
        clr_mask = wr_pend ? wr_bits : '0;
        mode_chg = wr_mode ? (wr_bits ^ mode_q) : '0;
        pend_d   = (mode_q & (rise | (pend_q & ~clr_mask)))
                 | (~mode_q & s2_q);
        pend_d   = pend_d & ~mode_chg;
    end

    // Enable and mode registers load straight from the bus.
    always_comb begin
        enable_d = wr_enable ? wr_bits : enable_q;
        mode_d   = wr_mode ? wr_bits : mode_q;
    end

    // Fixed priority: the lowest set index wins.
    always_comb begin
        req_id = NONE_ID;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_id = 3'(i);
            end
        end
    end

    // Sources strictly higher in priority than the one in service.
    always_comb begin
        lower_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            lower_mask[i] = (3'(i) < cur_id_q);
        end
    end

    // Service tracking: one level only, ENTRY is ignored while busy.
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        hwint    = '0;
        unique case (state_q)
            IDLE: begin
                hwint = req;
                if (exl_op == EXL_ENTRY) begin
                    if (|req) begin
                        state_d  = SERVICE;
                        cur_id_d = req_id;
                    end else begin
                        state_d  = EXCEPT;
                        cur_id_d = NONE_ID;
                    end
                end
            end
            SERVICE: begin
                hwint = req & lower_mask;
                if (exl_op == EXL_ERET) begin
                    state_d  = IDLE;
                    cur_id_d = NONE_ID;
                end
            end
            EXCEPT: begin
                if (exl_op == EXL_ERET) begin
                    state_d  = IDLE;
                    cur_id_d = NONE_ID;
                end
            end
            default: begin
                state_d  = IDLE;
                cur_id_d = NONE_ID;
            end
        endcase
    end

    // Combinational register read-back; idle bus reads as zero.
    always_comb begin
        rdata = '0;
        if (sel) begin
            unique case (addr)
                ADDR_PEND:   rdata = {{(32-NSRC){1'b0}}, pend_q};
                ADDR_ENABLE: rdata = {{(32-NSRC){1'b0}}, enable_q};
                ADDR_MODE:   rdata = {{(32-NSRC){1'b0}}, mode_q};
                ADDR_STATUS: rdata = {24'b0, state_q, 3'b0, cur_id_q};
                default:     rdata = '0;
            endcase
        end
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Software-visible registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q   <= '0;
            enable_q <= ENABLE_RST;
            mode_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
        end
    end

    // Service state; reset drops any service in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_id_q <= NONE_ID;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed checks of int_ctrl latching, priority,
// exception path, reset behaviour and mode switching.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_src;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  exl_op;
    logic [5:0]  hwint;
    logic [2:0]  cur_id;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    int_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .irq_src(irq_src),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .exl_op (exl_op),
        .hwint  (hwint),
        .cur_id (cur_id)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        sel   = 1'b0;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        v    = rdata;
        sel  = 1'b0;
    endtask

    task automatic exl(input logic [1:0] op);
        exl_op = op;
        @(negedge clk);
        exl_op = 2'd0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset   = 1'b0;
        sel     = 1'b0;
        we      = 1'b0;
        addr    = 2'd1;
        wdata   = '0;
        exl_op  = 2'd0;
        irq_src = 6'h3F;
        #45;
        total++;
        if (hwint !== 6'h00) begin
            bad++; $display("FAIL reset_hwint got=%h exp=00", hwint);
        end
        total++;
        if (cur_id !== 3'd7) begin
            bad++; $display("FAIL reset_cur_id got=%0d exp=7", cur_id);
        end
        total++;
        if (rdata !== 32'h0) begin
            bad++; $display("FAIL reset_nosel got=%h exp=0", rdata);
        end
        rd(2'd1, v);
        total++;
        if (v !== 32'h3F) begin
            bad++; $display("FAIL reset_enable got=%h exp=3f", v);
        end
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL reset_pend got=%h exp=0", v);
        end
        rd(2'd2, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL reset_mode got=%h exp=0", v);
        end
        rd(2'd3, v);
        total++;
        if (v !== 32'h07) begin
            bad++; $display("FAIL reset_status got=%h exp=07", v);
        end
        irq_src = 6'h00;
        @(negedge clk);
        reset = 1'b1;
        step(4);
    endtask

    task automatic test_edge_latch();
        logic [31:0] v;
        bus_write(2'd2, 32'h3F);
        irq_src = 6'h04;
        @(negedge clk);
        irq_src = 6'h00;
        @(negedge clk);
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL edge_early got=%h exp=0", v);
        end
        @(negedge clk);
        rd(2'd0, v);
        total++;
        if (v !== 32'h04) begin
            bad++; $display("FAIL edge_pend got=%h exp=04", v);
        end
        total++;
        if (hwint !== 6'h04) begin
            bad++; $display("FAIL edge_hwint got=%h exp=04", hwint);
        end
        step(3);
        rd(2'd0, v);
        total++;
        if (v !== 32'h04 || hwint !== 6'h04) begin
            bad++; $display("FAIL edge_hold pend=%h hwint=%h exp=04/04", v, hwint);
        end
        @(negedge clk);
        bus_write(2'd0, 32'h04);
        rd(2'd0, v);
        total++;
        if (v !== 32'h0 || hwint !== 6'h00) begin
            bad++; $display("FAIL edge_clear pend=%h hwint=%h exp=0/0", v, hwint);
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [31:0] v;
        bus_write(2'd2, 32'h00);
        irq_src = 6'b101000;
        step(3);
        total++;
        if (hwint !== 6'h28) begin
            bad++; $display("FAIL prio_idle_hwint got=%h exp=28", hwint);
        end
        exl(2'd1);
        total++;
        if (cur_id !== 3'd3) begin
            bad++; $display("FAIL prio_cur_id got=%0d exp=3", cur_id);
        end
        rd(2'd3, v);
        total++;
        if (v !== 32'h43) begin
            bad++; $display("FAIL prio_status got=%h exp=43", v);
        end
        total++;
        if (hwint !== 6'h00) begin
            bad++; $display("FAIL prio_svc_hwint got=%h exp=00", hwint);
        end
        @(negedge clk);
        exl(2'd1);
        total++;
        if (cur_id !== 3'd3) begin
            bad++; $display("FAIL prio_nest got=%0d exp=3", cur_id);
        end
        irq_src = 6'b101010;
        step(3);
        total++;
        if (hwint !== 6'h02) begin
            bad++; $display("FAIL prio_preempt got=%h exp=02", hwint);
        end
        exl(2'd2);
        rd(2'd3, v);
        total++;
        if (v !== 32'h07 || cur_id !== 3'd7) begin
            bad++; $display("FAIL prio_eret status=%h id=%0d exp=07/7", v, cur_id);
        end
        total++;
        if (hwint !== 6'h2A) begin
            bad++; $display("FAIL prio_eret_hwint got=%h exp=2a", hwint);
        end
        irq_src = 6'h00;
        step(4);
    endtask

    task automatic test_race();
        logic [31:0] v;
        bus_write(2'd2, 32'h3F);
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL race_pre got=%h exp=0", v);
        end
        @(negedge clk);
        irq_src = 6'h01;
        @(negedge clk);
        irq_src = 6'h00;
        @(negedge clk);
        bus_write(2'd0, 32'h01);
        rd(2'd0, v);
        total++;
        if (v !== 32'h01) begin
            bad++; $display("FAIL race_set_wins got=%h exp=01", v);
        end
        @(negedge clk);
        bus_write(2'd0, 32'h01);
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL race_clear got=%h exp=0", v);
        end
        @(negedge clk);
    endtask

    task automatic test_except();
        logic [31:0] v;
        exl(2'd1);
        rd(2'd3, v);
        total++;
        if (v !== 32'h87 || cur_id !== 3'd7) begin
            bad++; $display("FAIL exc_status got=%h id=%0d exp=87/7", v, cur_id);
        end
        @(negedge clk);
        irq_src = 6'h20;
        @(negedge clk);
        irq_src = 6'h00;
        step(2);
        rd(2'd0, v);
        total++;
        if (v !== 32'h20) begin
            bad++; $display("FAIL exc_pend got=%h exp=20", v);
        end
        total++;
        if (hwint !== 6'h00) begin
            bad++; $display("FAIL exc_hwint got=%h exp=00", hwint);
        end
        @(negedge clk);
        bus_write(2'd3, 32'hFF);
        exl(2'd1);
        rd(2'd3, v);
        total++;
        if (v !== 32'h87) begin
            bad++; $display("FAIL exc_ignore got=%h exp=87", v);
        end
        @(negedge clk);
        exl(2'd2);
        rd(2'd3, v);
        total++;
        if (v !== 32'h07 || hwint !== 6'h20) begin
            bad++; $display("FAIL exc_eret status=%h hwint=%h exp=07/20", v, hwint);
        end
        @(negedge clk);
        bus_write(2'd1, 32'h1F);
        total++;
        if (hwint !== 6'h00) begin
            bad++; $display("FAIL exc_enable_mask got=%h exp=00", hwint);
        end
        exl(2'd3);
        rd(2'd3, v);
        total++;
        if (v !== 32'h07) begin
            bad++; $display("FAIL exc_op3 got=%h exp=07", v);
        end
        @(negedge clk);
        bus_write(2'd1, 32'h3F);
        bus_write(2'd0, 32'h20);
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL exc_cleanup got=%h exp=0", v);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] v;
        bus_write(2'd1, 32'h0F);
        irq_src = 6'h02;
        @(negedge clk);
        irq_src = 6'h00;
        step(2);
        total++;
        if (hwint !== 6'h02) begin
            bad++; $display("FAIL rms_hwint got=%h exp=02", hwint);
        end
        exl(2'd1);
        total++;
        if (cur_id !== 3'd1) begin
            bad++; $display("FAIL rms_cur_id got=%0d exp=1", cur_id);
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (cur_id !== 3'd7 || hwint !== 6'h00) begin
            bad++; $display("FAIL rms_async id=%0d hwint=%h exp=7/00", cur_id, hwint);
        end
        rd(2'd1, v);
        total++;
        if (v !== 32'h3F) begin
            bad++; $display("FAIL rms_enable got=%h exp=3f", v);
        end
        rd(2'd3, v);
        total++;
        if (v !== 32'h07) begin
            bad++; $display("FAIL rms_status got=%h exp=07", v);
        end
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL rms_pend got=%h exp=0", v);
        end
        rd(2'd2, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL rms_mode got=%h exp=0", v);
        end
        reset = 1'b1;
        step(3);
    endtask

    task automatic test_mode_switch();
        logic [31:0] v;
        bus_write(2'd2, 32'h3F);
        irq_src = 6'h10;
        step(3);
        rd(2'd0, v);
        total++;
        if (v !== 32'h10) begin
            bad++; $display("FAIL ms_edge got=%h exp=10", v);
        end
        @(negedge clk);
        bus_write(2'd2, 32'h00);
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL ms_clear got=%h exp=0", v);
        end
        @(negedge clk);
        rd(2'd0, v);
        total++;
        if (v !== 32'h10) begin
            bad++; $display("FAIL ms_follow got=%h exp=10", v);
        end
        @(negedge clk);
        bus_write(2'd0, 32'h10);
        rd(2'd0, v);
        total++;
        if (v !== 32'h10) begin
            bad++; $display("FAIL ms_level_noclr got=%h exp=10", v);
        end
        irq_src = 6'h00;
        step(3);
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL ms_fall got=%h exp=0", v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_edge_latch();
        test_priority();
        test_race();
        test_except();
        test_reset_mid_service();
        test_mode_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
